secure_credential_tx: RTL and testbench

SECURE_CREDENTIAL_TX -- requirements
Module: secure_credential_tx

---
 rtl/secure_credential_tx.sv | 152 +++++++++++++++
 tb/tb_secure_credential_tx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/secure_credential_tx.sv
// Credential obfuscation transmitter.
// A session key seeds a Galois LFSR. Incoming plaintext beats are buffered
// until in_last arrives. The beats are then streamed out XORed with the
// keystream. The buffer is scrubbed afterwards, and the key is consumed.
//
// state | meaning
// IDLE  | waiting for key_load / first beat (in_ready follows key_ok)
// LOAD  | collecting plaintext beats into the buffer
// SEND  | streaming buffer[idx] ^ keystream on the output handshake
// CLEAR | one-cycle scrub of buffer, counters, LFSR and key_ok
module secure_credential_tx #(
  parameter int                DATA_W = 8,
  parameter int                DEPTH  = 16,
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS   = 16'hB400
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [LFSR_W-1:0] key_in,
  input  logic              key_load,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              err
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, CLEAR} state_t;

  state_t            state;
  logic [DATA_W-1:0] buffer [DEPTH];
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  idx;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_next;
  logic [LFSR_W-1:0] key_reg;
  logic              key_ok;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Galois step of the keystream register.
  assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);

  // Output is gated so that buffered plaintext never leaks when idle.
  assign out_data = out_valid ? (buffer[idx[IDX_W-1:0]] ^ lfsr[DATA_W-1:0]) : '0;

  // Control FSM with all handshake/status outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      for (int i = 0; i < DEPTH; i++) buffer[i] <= '0;
      count     <= '0;
      idx       <= '0;
      lfsr      <= '0;
      key_reg   <= '0;
      key_ok    <= 1'b0;
      err       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (key_load) begin
            if (key_in != '0) begin
              key_reg  <= key_in;
              key_ok   <= 1'b1;
              err      <= 1'b0;
              in_ready <= 1'b1;
            end else begin
              key_ok   <= 1'b0;
              err      <= 1'b1;
              in_ready <= 1'b0;
            end
          end
          // A beat accepted alongside a key_load still uses the key already held.
          if (in_fire) begin
            buffer[0] <= in_data;
            count     <= ONE;
            idx       <= '0;
            lfsr      <= key_reg;
            busy      <= 1'b1;
            if (in_last) begin
              state     <= SEND;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_last  <= 1'b1;
            end else begin
              state    <= LOAD;
              in_ready <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (in_fire) begin
            buffer[count[IDX_W-1:0]] <= in_data;
            count <= count + ONE;
            if (in_last) begin
              state     <= SEND;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_last  <= 1'b0;
            end else if (count == LAST_IDX) begin
              state    <= CLEAR;
              in_ready <= 1'b0;
              err      <= 1'b1;
            end
          end
        end
        SEND: begin
          if (out_fire) begin
            idx  <= idx + ONE;
            lfsr <= lfsr_next;
            if (out_last) begin
              state     <= CLEAR;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              out_last <= ((idx + ONE) == (count - ONE));
            end
          end
        end
        CLEAR: begin
          for (int i = 0; i < DEPTH; i++) buffer[i] <= '0;
          count    <= '0;
          idx      <= '0;
          lfsr     <= '0;
          key_ok   <= 1'b0;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_secure_credential_tx.sv
// Directed bench for secure_credential_tx: a cycle table for the basic flow
// plus hand-written sequences for stalls, overflow, reset and key reuse.
module tb_secure_credential_tx;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] key_in = '0;
  logic        key_load = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        busy;
  logic        err;

  int n_total = 0;
  int n_pass  = 0;

  secure_credential_tx dut (
    .clk(clk), .reset_n(reset_n), .key_in(key_in), .key_load(key_load),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        kl;
    logic [15:0] key;
    logic        iv;
    logic [7:0]  id;
    logic        il;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [7:0]  e_od;
    logic        e_ol;
    logic        e_busy;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic kl, input logic [15:0] key, input logic iv,
                              input logic [7:0] id, input logic il, input logic ordy,
                              input logic ir, input logic ov, input logic [7:0] od,
                              input logic ol, input logic bz, input logic er);
    vec_t v;
    v.kl = kl; v.key = key; v.iv = iv; v.id = id; v.il = il; v.ordy = ordy;
    v.e_ir = ir; v.e_ov = ov; v.e_od = od; v.e_ol = ol; v.e_busy = bz; v.e_err = er;
    return v;
  endfunction

  function automatic logic [15:0] step(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    key_load = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic load_key(input logic [15:0] k);
    key_in = k; key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d, input logic last);
    in_valid = 1'b1; in_data = d; in_last = last;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // {in_ready, out_valid, out_data, out_last, busy, err}
  function automatic logic [12:0] outs();
    return {in_ready, out_valid, out_data, out_last, busy, err};
  endfunction

  initial begin
    logic [15:0] l;
    logic [7:0]  d;
    logic        saw_ov;
    logic        all_rdy;
    logic [7:0]  bor;

    do_reset();
    check("reset_outputs", 32'(outs()), 32'h0);

    // Two-beat credential, zero-key rejection, single-beat credential with a stall.
    vecs.push_back(mk(1, 16'hACE1, 0, 8'h00, 0, 0,  1, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 8'h55, 0, 0,  1, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 8'h00, 1, 1,  0, 1, 8'hB4, 0, 1, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 8'h00, 0, 1,  0, 1, 8'h70, 1, 1, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 8'h00, 0, 1,  0, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(1, 16'h0000, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 0, 1));
    vecs.push_back(mk(0, 16'h0000, 1, 8'h12, 0, 0,  0, 0, 8'h00, 0, 0, 1));
    vecs.push_back(mk(1, 16'hACE1, 0, 8'h00, 0, 0,  1, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 8'hAA, 1, 0,  0, 1, 8'h4B, 1, 1, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 8'h00, 0, 0,  0, 1, 8'h4B, 1, 1, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 8'h00, 0, 1,  0, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 0, 0));

    foreach (vecs[i]) begin
      key_load = vecs[i].kl; key_in = vecs[i].key; in_valid = vecs[i].iv;
      in_data = vecs[i].id; in_last = vecs[i].il; out_ready = vecs[i].ordy;
      tick();
      check($sformatf("vec%0d", i), 32'(outs()),
            32'({vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_od, vecs[i].e_ol,
                 vecs[i].e_busy, vecs[i].e_err}));
    end
    idle_in();

    // Output stalls: data must hold while out_ready is low.
    do_reset();
    load_key(16'hACE1);
    beat(8'h55, 1'b0);
    beat(8'h00, 1'b1);
    check("stall_first", {23'h0, out_valid, out_data, out_last}, {23'h0, 1'b1, 8'hB4, 1'b0});
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall_hold%0d", i), {23'h0, out_valid, out_data, out_last},
            {23'h0, 1'b1, 8'hB4, 1'b0});
    end
    out_ready = 1'b1; tick();
    check("stall_second", {23'h0, out_valid, out_data, out_last}, {23'h0, 1'b1, 8'h70, 1'b1});
    out_ready = 1'b0; tick();
    check("stall_second_hold", {23'h0, out_valid, out_data, out_last}, {23'h0, 1'b1, 8'h70, 1'b1});
    out_ready = 1'b1; tick();
    check("stall_done", {30'h0, out_valid, busy}, {30'h0, 1'b0, 1'b1});
    out_ready = 1'b0; tick();
    check("stall_idle_busy", {31'h0, busy}, 32'h0);

    // Overflow: DEPTH beats with no in_last.
    load_key(16'h1D2C);
    saw_ov = 1'b0; all_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      all_rdy &= in_ready;
      saw_ov |= out_valid;
      beat(8'(i + 8'h30), 1'b0);
      saw_ov |= out_valid;
    end
    check("ovf_all_accepted", {31'h0, all_rdy}, 32'h1);
    check("ovf_err_clear", {28'h0, err, busy, in_ready, out_valid}, {28'h0, 4'b1100});
    tick();
    saw_ov |= out_valid;
    check("ovf_no_out_valid", {31'h0, saw_ov}, 32'h0);
    check("ovf_idle", {29'h0, busy, err, in_ready}, {29'h0, 3'b010});
    bor = '0;
    for (int i = 0; i < 16; i++) bor |= dut.buffer[i];
    check("ovf_buffer_zero", {24'h0, bor}, 32'h0);

    // Full-depth credential (in_last on beat 16); key_load during SEND is ignored.
    load_key(16'h1234);
    check("full_key_clears_err", {30'h0, err, in_ready}, {30'h0, 2'b01});
    for (int i = 0; i < 16; i++) beat(8'(i * 17 + 3), i == 15);
    check("full_no_err", {30'h0, err, in_ready}, 32'h0);
    l = 16'h1234;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      d = 8'(i * 17 + 3) ^ l[7:0];
      check($sformatf("full_beat%0d", i), {22'h0, out_valid, out_data, out_last},
            {22'h0, 1'b1, d, (i == 15)});
      key_load = (i == 5); key_in = 16'hFFFF;
      tick();
      key_load = 1'b0;
      l = step(l);
    end
    check("full_done", {30'h0, out_valid, busy}, {30'h0, 2'b01});
    out_ready = 1'b0;
    tick();

    // Key is single-use: no beats without a fresh key_load.
    in_valid = 1'b1; in_data = 8'h77; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("reuse_blocked%0d", i), {29'h0, in_ready, busy, out_valid}, 32'h0);
    end
    idle_in();

    // Asynchronous reset in the middle of SEND.
    load_key(16'hACE1);
    beat(8'h55, 1'b0);
    beat(8'h00, 1'b1);
    out_ready = 1'b1; tick();
    check("rst_pre", {23'h0, out_valid, out_data, out_last}, {23'h0, 1'b1, 8'h70, 1'b1});
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_outputs", 32'(outs()), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    in_valid = 1'b1; in_data = 8'h99; in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst_no_ready%0d", i), {30'h0, in_ready, busy}, 32'h0);
    end
    in_valid = 1'b0;
    load_key(16'hACE1);
    check("rst_rekey_ready", {30'h0, in_ready, err}, {30'h0, 2'b10});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
